// File: rtl/d5m_stream_gen.sv
// d5m_stream_gen: synthetic D5M sensor transmitter producing FVAL/LVAL-framed 12-bit Bayer test patterns
module d5m_stream_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 32,
  parameter int FV2LV    = 4,
  parameter int LV2FV    = 4
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSTART,
  input  logic        iEND,
  input  logic [1:0]  iPATTERN,
  output logic [11:0] oDATA,
  output logic        oLVAL,
  output logic        oFVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oBUSY
);
  typedef enum logic [2:0] {IDLE, FRONT, LINE, HBLANK, BACK, VBLANK} state_t;
  localparam logic [15:0] H_W     = 16'(H_ACTIVE);
  localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
  localparam logic [15:0] FV_LAST = 16'(FV2LV - 1);
  localparam logic [15:0] LV_LAST = 16'(LV2FV - 1);
  state_t      state;
  logic [15:0] cnt, acc, acc_sum, acc_nxt, x_nxt, y_nxt;
  logic [2:0]  bar, bar_nxt;
  logic [1:0]  pat;
  logic [11:0] pix_nxt;
  logic        stop, wrap;
  function automatic logic [11:0] pix(input logic [1:0] p, input logic [11:0] x, input logic [11:0] y,
                                      input logic [2:0] b, input logic [11:0] f);
    logic s;
    s = (x[0] == y[0]) ? b[1] : (x[0] ? b[2] : b[0]);
    return p == 2'd0 ? x : p == 2'd1 ? y : p == 2'd2 ? {12{s}} : f;
  endfunction
  // next pixel position and bar index; acc tracks (X*8) mod H_ACTIVE so bars need no divider
  always_comb begin
    acc_sum = acc + 16'd8;
    wrap    = acc_sum >= H_W;
    x_nxt   = state == LINE ? oX_Cont + 16'd1 : 16'd0;
    acc_nxt = state != LINE ? 16'd0 : wrap ? acc_sum - H_W : acc_sum;
    bar_nxt = state != LINE ? 3'd0 : wrap ? bar + 3'd1 : bar;
    y_nxt   = state == HBLANK ? oY_Cont + 16'd1 : oY_Cont;
    pix_nxt = pix(pat, x_nxt[11:0], y_nxt[11:0], bar_nxt, oFrame_Cont[11:0]);
  end
  // frame timing FSM with registered outputs and sticky stop request
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      bar         <= '0;
      pat         <= '0;
      stop        <= 1'b0;
      oDATA       <= '0;
      oLVAL       <= 1'b0;
      oFVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      oBUSY       <= 1'b0;
    end else begin
      if (state != IDLE && iEND) stop <= 1'b1;
      case (state)
        IDLE: if (iSTART && !iEND) begin
          state <= FRONT;
          cnt   <= '0;
          pat   <= iPATTERN;
          oFVAL <= 1'b1;
          oBUSY <= 1'b1;
        end
        FRONT, HBLANK: if ((state == FRONT && cnt == FV_LAST) || (state == HBLANK && cnt == HB_LAST)) begin
          state   <= LINE;
          oLVAL   <= 1'b1;
          oX_Cont <= x_nxt;
          oY_Cont <= y_nxt;
          acc     <= acc_nxt;
          bar     <= bar_nxt;
          oDATA   <= pix_nxt;
        end else cnt <= cnt + 16'd1;
        LINE: if (oX_Cont == X_LAST) begin
          oLVAL   <= 1'b0;
          oX_Cont <= '0;
          oDATA   <= '0;
          cnt     <= '0;
          state   <= oY_Cont == Y_LAST ? BACK : HBLANK;
          if (oY_Cont == Y_LAST) oY_Cont <= '0;
        end else begin
          oX_Cont <= x_nxt;
          acc     <= acc_nxt;
          bar     <= bar_nxt;
          oDATA   <= pix_nxt;
        end
        BACK: if (cnt == LV_LAST) begin
          state       <= VBLANK;
          cnt         <= '0;
          oFVAL       <= 1'b0;
          oFrame_Cont <= oFrame_Cont + 32'd1;
        end else cnt <= cnt + 16'd1;
        VBLANK: if (cnt == VB_LAST) begin
          cnt <= '0;
          if (stop || iEND) begin
            state <= IDLE;
            stop  <= 1'b0;
            oBUSY <= 1'b0;
          end else begin
            state <= FRONT;
            pat   <= iPATTERN;
            oFVAL <= 1'b1;
          end
        end else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_d5m_stream_gen.sv
// tb_d5m_stream_gen: randomized checks of d5m_stream_gen against a frame-position reference model
module tb_d5m_stream_gen;
  localparam int H = 8, V = 4, HB = 3, VB = 5, FL = 2, LF = 2;
  localparam int LP = H + HB;
  localparam int FH = FL + V * H + (V - 1) * HB + LF;
  localparam int P  = FH + VB;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, req_end = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic [11:0] oDATA;
  logic oLVAL, oFVAL, oBUSY;
  logic [15:0] oX_Cont, oY_Cont;
  logic [31:0] oFrame_Cont;
  logic [78:0] dut_vec;
  int vectors = 0, miscompares = 0;
  logic m_busy, m_stop;
  int m_t;
  logic [31:0] m_frames;
  logic [1:0] m_pat;
  d5m_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB), .FV2LV(FL), .LV2FV(LF)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iEND(req_end), .iPATTERN(pattern),
    .oDATA(oDATA), .oLVAL(oLVAL), .oFVAL(oFVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
    .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY));
  assign dut_vec = {oDATA, oLVAL, oFVAL, oX_Cont, oY_Cont, oFrame_Cont, oBUSY};
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [11:0] model_pixel(input logic [1:0] p, input int col, input int ln, input logic [31:0] f);
    int b;
    logic on;
    b = col * 8 / H;
    if (ln % 2 == 0) on = (col % 2 == 0) ? b[1] : b[2];
    else on = (col % 2 == 0) ? b[0] : b[1];
    case (p)
      2'd0: return col[11:0];
      2'd1: return ln[11:0];
      2'd2: return on ? 12'hFFF : 12'h000;
      default: return f[11:0];
    endcase
  endfunction
  function automatic logic [78:0] exp_vec();
    int u, ln, col;
    logic inl, lv, fv;
    logic [15:0] x, y;
    logic [11:0] d;
    u   = m_t - FL;
    inl = m_busy && u >= 0 && u < V * LP - HB;
    ln  = inl ? u / LP : 0;
    col = inl ? u % LP : 0;
    lv  = inl && col < H;
    fv  = m_busy && m_t < FH;
    x   = lv ? 16'(col) : 16'd0;
    y   = inl ? 16'(ln) : 16'd0;
    d   = lv ? model_pixel(m_pat, col, ln, m_frames) : 12'd0;
    return {d, lv, fv, x, y, m_frames, m_busy};
  endfunction
  task automatic model_reset();
    m_busy = 1'b0; m_stop = 1'b0; m_t = 0; m_frames = '0; m_pat = 2'd0;
  endtask
  task automatic tick(input logic s, input logic e, input logic [1:0] p);
    start = s; req_end = e; pattern = p;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (!m_busy) begin
      if (s && !e) begin m_busy = 1'b1; m_t = 0; m_pat = p; end
    end else begin
      m_stop = m_stop || e;
      if (m_t == P - 1) begin
        m_t = 0;
        if (m_stop) begin m_busy = 1'b0; m_stop = 1'b0; end
        else m_pat = p;
      end else begin
        m_t++;
        if (m_t == FH) m_frames++;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    start = 1'b0; req_end = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    start = 1'b1; req_end = 1'b0; rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (dut_vec !== 79'd0) begin miscompares++; $display("FAIL reset cycle %0d dut=%h exp=0", i, dut_vec); end
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_h_ramp();
    int hi, rise2;
    logic prev, fell;
    do_reset();
    tick(1'b1, 1'b0, 2'd0);
    vectors++;
    if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL h_ramp start dut=%h exp=%h", dut_vec, exp_vec()); end
    hi = oFVAL ? 1 : 0; prev = oFVAL; rise2 = -1; fell = 1'b0;
    for (int i = 1; i < 2 * P + 5; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b0, 2'd0);
      vectors++;
      if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL h_ramp cycle %0d dut=%h exp=%h", i, dut_vec, exp_vec()); end
      if (i < P && oFVAL) hi++;
      if (oFVAL && !prev && rise2 < 0) rise2 = i;
      if (!oFVAL && prev && !fell) begin
        fell = 1'b1;
        vectors++;
        if (oFrame_Cont !== 32'd1) begin miscompares++; $display("FAIL h_ramp frame_cont_at_fall got %0d want 1", oFrame_Cont); end
      end
      prev = oFVAL;
    end
    vectors++;
    if (hi != FH) begin miscompares++; $display("FAIL h_ramp fval_high got %0d want %0d", hi, FH); end
    vectors++;
    if (rise2 != P) begin miscompares++; $display("FAIL h_ramp period got %0d want %0d", rise2, P); end
  endtask
  task automatic test_bars();
    do_reset();
    tick(1'b1, 1'b0, 2'd2);
    for (int i = 0; i < P + 2; i++) begin
      tick(1'b0, 1'b0, 2'd2);
      vectors++;
      if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL bars cycle %0d dut=%h exp=%h", i, dut_vec, exp_vec()); end
    end
  endtask
  task automatic test_stop();
    int n, hi, fall_at, guard;
    logic [1:0] p;
    p = 2'($urandom_range(0, 3));
    do_reset();
    tick(1'b1, 1'b0, p);
    n = 0; hi = oFVAL ? 1 : 0; guard = 0;
    while (!(m_frames == 2 && m_t == FL + 2 * LP + 3) && guard < 4 * P) begin
      tick(1'b0, 1'b0, p);
      n++; guard++;
      if (oFVAL) hi++;
      vectors++;
      if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL stop run cycle %0d dut=%h exp=%h", n, dut_vec, exp_vec()); end
    end
    tick(1'b0, 1'b1, p);
    n++;
    if (oFVAL) hi++;
    fall_at = -1;
    for (int i = 0; i < 2 * P; i++) begin
      tick(1'($urandom_range(0, 1)) & oBUSY, 1'b0, p);
      n++;
      if (oFVAL) hi++;
      if (!oBUSY && fall_at < 0) fall_at = n;
      vectors++;
      if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL stop tail cycle %0d dut=%h exp=%h", n, dut_vec, exp_vec()); end
    end
    vectors++;
    if (fall_at != 3 * P) begin miscompares++; $display("FAIL stop busy_fall got %0d want %0d", fall_at, 3 * P); end
    vectors++;
    if (hi != 3 * FH) begin miscompares++; $display("FAIL stop fval_cycles got %0d want %0d", hi, 3 * FH); end
    vectors++;
    if (oFrame_Cont !== 32'd3) begin miscompares++; $display("FAIL stop frame_cont got %0d want 3", oFrame_Cont); end
  endtask
  task automatic test_idle_both();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b1, 2'($urandom_range(0, 3)));
      vectors++;
      if (oFVAL !== 1'b0 || oBUSY !== 1'b0 || dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL idle_both cycle %0d dut=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask
  task automatic test_pat_switch();
    int lv2, bad2;
    do_reset();
    tick(1'b1, 1'b0, 2'd1);
    lv2 = 0; bad2 = 0;
    for (int i = 1; i < 2 * P; i++) begin
      tick(1'b0, 1'b0, i < 10 + int'($urandom_range(0, 20)) ? 2'd1 : 2'd3);
      if (i < 31) pattern = 2'd1;
      vectors++;
      if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL pat_switch cycle %0d dut=%h exp=%h", i, dut_vec, exp_vec()); end
      if (i >= P && oLVAL) begin lv2++; if (oDATA !== 12'h001) bad2++; end
    end
    vectors++;
    if (lv2 != V * H || bad2 != 0) begin
      miscompares++; $display("FAIL pat_switch frame2 lval_cycles %0d want %0d, non_001 %0d want 0", lv2, V * H, bad2);
    end
  endtask
  task automatic test_async_reset();
    int guard;
    do_reset();
    tick(1'b1, 1'b0, 2'd0);
    guard = 0;
    while (!(oLVAL && oX_Cont == 16'd3) && guard < P) begin tick(1'b0, 1'b0, 2'd0); guard++; end
    vectors++;
    if (!oLVAL) begin miscompares++; $display("FAIL async_reset no_line_seen lval=%b want 1", oLVAL); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dut_vec !== 79'd0) begin miscompares++; $display("FAIL async_reset immediate dut=%h exp=0", dut_vec); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      vectors++;
      if (dut_vec !== 79'd0) begin miscompares++; $display("FAIL async_reset quiet cycle %0d dut=%h exp=0", i, dut_vec); end
    end
    tick(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b0, 2'd0);
      vectors++;
      if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL async_reset restart cycle %0d dut=%h exp=%h", i, dut_vec, exp_vec()); end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 79) == 0), 2'($urandom_range(0, 3)));
      vectors++;
      if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL random cycle %0d dut=%h exp=%h", i, dut_vec, exp_vec()); end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_h_ramp();
    test_bars();
    test_stop();
    test_idle_both();
    test_pat_switch();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
